// File: rtl/sb_arbiter_pkg.sv
// sb_arbiter_pkg: shared widths, byte-select codes, FSM states and request legality
package sb_arbiter_pkg;

    localparam int MEM_ADDR_WIDTH = 32;
    localparam int MEM_DATA_WIDTH = 32;

    localparam logic [1:0] SEL_BYTE = 2'b00;
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_WORD = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        IF_WAIT = 2'b01,
        EX_WAIT = 2'b10
    } state_t;

    function automatic logic ex_illegal(input logic re, input logic we, input logic [1:0] sel,
                                        input logic [1:0] off);
        return (re & we) | (sel == SEL_NONE) | ((sel == SEL_HALF) & off[0]) |
               ((sel == SEL_WORD) & (|off));
    endfunction

endpackage

// File: rtl/sb_arbiter_if.sv
// sb_arbiter_if: single-port system bus between the arbiter and memory
interface sb_arbiter_if;
    import sb_arbiter_pkg::*;

    logic                      req;
    logic                      we;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] wdata;
    logic [3:0]                be;
    logic                      ack;
    logic [MEM_DATA_WIDTH-1:0] rdata;

    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);

endinterface

// File: rtl/sb_arbiter_lane_align.sv
// sb_arbiter_lane_align: store lane replication/byte enables and load shift/extension
module sb_arbiter_lane_align
    import sb_arbiter_pkg::*;
(
    input  logic [1:0]                st_off,
    input  logic [1:0]                st_sel,
    input  logic [MEM_DATA_WIDTH-1:0] st_data,
    output logic [MEM_DATA_WIDTH-1:0] st_wdata,
    output logic [3:0]                st_be,
    input  logic [1:0]                ld_off,
    input  logic [1:0]                ld_sel,
    input  logic                      ld_uns,
    input  logic [MEM_DATA_WIDTH-1:0] ld_data,
    output logic [MEM_DATA_WIDTH-1:0] ld_result
);

    logic [MEM_DATA_WIDTH-1:0] sh;

    assign st_wdata = (st_sel == SEL_BYTE) ? {4{st_data[7:0]}} :
                      (st_sel == SEL_HALF) ? {2{st_data[15:0]}} : st_data;
    assign st_be    = (st_sel == SEL_BYTE) ? 4'b0001 << st_off :
                      (st_sel == SEL_HALF) ? (st_off[1] ? 4'b1100 : 4'b0011) :
                      (st_sel == SEL_WORD) ? 4'b1111 : 4'b0000;

    assign sh        = ld_data >> {ld_off, 3'b000};
    assign ld_result = (ld_sel == SEL_BYTE) ? {{24{~ld_uns & sh[7]}}, sh[7:0]} :
                       (ld_sel == SEL_HALF) ? {{16{~ld_uns & sh[15]}}, sh[15:0]} : sh;

endmodule

// File: rtl/sb_arbiter.sv
// sb_arbiter: shares one bus port between fetch and load/store, with a watchdog abort
module sb_arbiter
    import sb_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req_i,
    input  logic [MEM_ADDR_WIDTH-1:0] if_addr_i,
    output logic                      if_gnt_o,
    output logic                      if_rvalid_o,
    output logic [MEM_DATA_WIDTH-1:0] if_rdata_o,
    input  logic                      ex_re_i,
    input  logic                      ex_we_i,
    input  logic [MEM_ADDR_WIDTH-1:0] ex_addr_i,
    input  logic [MEM_DATA_WIDTH-1:0] ex_wdata_i,
    input  logic [1:0]                ex_byte_sel_i,
    input  logic                      ex_unsigned_i,
    output logic                      ex_done_o,
    output logic [MEM_DATA_WIDTH-1:0] ex_rdata_o,
    output logic                      hold_o,
    output logic                      err_o,
    sb_arbiter_if.master              bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t                    state, state_nx;
    logic [CW-1:0]             cnt;
    logic                      req_q, we_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [MEM_DATA_WIDTH-1:0] wdata_q;
    logic [3:0]                be_q;
    logic [1:0]                l_off, l_sel;
    logic                      l_uns;
    logic                      ex_req, bad, timeout, issue_ex, issue_if;
    logic                      gnt, rvalid, done, err;
    logic [MEM_DATA_WIDTH-1:0] ird, erd, st_wdata, ld_result;
    logic [3:0]                st_be;
    logic                      unused_if_addr;

    assign ex_req         = ex_re_i | ex_we_i;
    assign bad            = ex_illegal(ex_re_i, ex_we_i, ex_byte_sel_i, ex_addr_i[1:0]);
    assign timeout        = cnt == CW'(TIMEOUT);
    assign unused_if_addr = ^if_addr_i[1:0];

    sb_arbiter_lane_align u_align (
        .st_off    (ex_addr_i[1:0]),
        .st_sel    (ex_byte_sel_i),
        .st_data   (ex_wdata_i),
        .st_wdata  (st_wdata),
        .st_be     (st_be),
        .ld_off    (l_off),
        .ld_sel    (l_sel),
        .ld_uns    (l_uns),
        .ld_data   (bus.rdata),
        .ld_result (ld_result)
    );

    // State, watchdog and the registered bus request held for the whole wait
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            l_off   <= '0;
            l_sel   <= '0;
            l_uns   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= (state == IDLE || state_nx == IDLE) ? '0 : cnt + CW'(1);
            if (issue_ex | issue_if) begin
                req_q   <= 1'b1;
                we_q    <= issue_ex & ex_we_i;
                addr_q  <= issue_ex ? {ex_addr_i[31:2], 2'b00} : {if_addr_i[31:2], 2'b00};
                wdata_q <= issue_ex ? st_wdata : '0;
                be_q    <= issue_ex ? st_be : 4'b1111;
                l_off   <= ex_addr_i[1:0];
                l_sel   <= ex_byte_sel_i;
                l_uns   <= ex_unsigned_i;
            end else if (state != IDLE && state_nx == IDLE) begin
                req_q   <= 1'b0;
                we_q    <= 1'b0;
                addr_q  <= '0;
                wdata_q <= '0;
                be_q    <= '0;
            end
        end
    end

    // Next state and pulses: ex beats fetch in IDLE; ack beats the watchdog in a wait
    always_comb begin
        state_nx = state;
        issue_ex = 1'b0;
        issue_if = 1'b0;
        gnt      = 1'b0;
        rvalid   = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        ird      = '0;
        erd      = '0;
        if (state == IDLE) begin
            if (ex_req) begin
                done     = bad;
                err      = bad;
                issue_ex = ~bad;
                state_nx = bad ? IDLE : EX_WAIT;
            end else if (if_req_i) begin
                issue_if = 1'b1;
                gnt      = 1'b1;
                state_nx = IF_WAIT;
            end
        end else begin
            state_nx = (bus.ack | timeout) ? IDLE : state;
            err      = ~bus.ack & timeout;
            if (state == IF_WAIT) begin
                rvalid = bus.ack | timeout;
                ird    = bus.ack ? bus.rdata : '0;
            end else begin
                done = bus.ack | timeout;
                erd  = (bus.ack & ~we_q) ? ld_result : '0;
            end
        end
    end

    assign bus.req     = req_q;
    assign bus.we      = we_q;
    assign bus.addr    = addr_q;
    assign bus.wdata   = wdata_q;
    assign bus.be      = be_q;

    assign if_gnt_o    = gnt & ~rst;
    assign if_rvalid_o = rvalid & ~rst;
    assign if_rdata_o  = rst ? '0 : ird;
    assign ex_done_o   = done & ~rst;
    assign ex_rdata_o  = rst ? '0 : erd;
    assign err_o       = err & ~rst;
    assign hold_o      = ~rst & ((ex_req & ~done) | (state == IF_WAIT & ~rvalid));

endmodule
